umi_mem_tester: RTL and testbench
=================================

Name: umi_mem_tester

Overview:
- Hardware UMI initiator (host side) that exercises a UMI memory responder such as umi_mem_agent, directly or through umi_fifo_flex.
- On start it runs two phases:
  - Write phase: writes COUNT words of a deterministic pattern to consecutive addresses.
  - Read phase: reads the same words back and compares each against the regenerated pattern.
- Reports busy/done/pass, an error count and the first failing address.
- Used in self-checking benches and as on-chip memory BIST driver.

Parameters:
- DW, 64, request/response data width in bits; power of two, 32..1024.
- AW, 64, address width.
- CW, 32, UMI command width.
- CNTW, 16, width of word-count and error-count fields.
- MAXOUT, 4, maximum outstanding requests; 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- count  in  CNTW  number of DW words to test; sampled at start.
- base_addr  in  AW  first dstaddr, DW/8-aligned; sampled at start.
- src_addr  in  AW  srcaddr placed on all requests; sampled at start.
- seed  in  32  pattern seed; sampled at start.
- busy  out  1  run in progress.
- done  out  1  run complete; held until next start or reset.
- pass  out  1  valid when done; 1 iff err_count==0.
- err_count  out  CNTW  mismatches and bad responses; saturating.
- first_err_addr  out  AW  address of first mismatching read.
- uhost_req_valid, uhost_req_ready  out/in  1  request handshake.
- uhost_req_cmd  out  CW  request command.
- uhost_req_dstaddr  out  AW  request destination address.
- uhost_req_srcaddr  out  AW  request source address.
- uhost_req_data  out  DW  request data.
- uhost_resp_valid  in  1  response valid.
- uhost_resp_ready  out  1  response ready.
- uhost_resp_cmd  in  CW  response command.
- uhost_resp_dstaddr  in  AW  response destination address.
- uhost_resp_srcaddr  in  AW  response source address.
- uhost_resp_data  in  DW  response data.

Behaviour:
- Reset values:
  - busy, done, pass, err_count, first_err_addr, uhost_req_valid, outstanding counter: all 0.
  - FSM enters IDLE.
  - uhost_resp_ready = 1 always, including during reset; responses received in IDLE or DONE are dropped.
- FSM states: IDLE, WRITE, WAIT_WR, READ, WAIT_RD, DONE.
  - IDLE/DONE + start:
    - Latch inputs; clear err_count, first_err_addr, done.
    - busy=1 next cycle.
    - Go to WRITE, or go to DONE with pass=1 when count==0 (done rises 1 cycle after start).
  - WRITE: issue write i = 0..count-1; after the last request handshake go to WAIT_WR.
  - WAIT_WR: when outstanding==0, go to READ.
  - READ: issue read i = 0..count-1; after the last handshake go to WAIT_RD.
  - WAIT_RD: when outstanding==0, go to DONE.
  - DONE: busy=0, done=1, pass=(err_count==0).
  - start while busy is ignored.
- Request i field values:
  - dstaddr = base_addr + i*(DW/8); AW-bit wrap-around, no error.
  - cmd fields:
    - opcode [4:0]: write 0x03, read 0x01.
    - size [7:5] = log2(DW/8).
    - len [15:8] = 0.
    - eom [22] = 1, eof [23] = 1.
    - All other bits 0.
  - data:
    - Write: 32-bit lane k = seed + (i<<4) + k, mod 2^32.
    - Read: data = 0.
- Request handshake:
  - Transfer occurs when valid && ready.
  - Once valid is asserted, cmd/dstaddr/srcaddr/data stay stable and valid stays high until the transfer.
  - Back-to-back requests are allowed (one per cycle).
  - valid is not asserted while outstanding==MAXOUT.
- Outstanding counter:
  - +1 on request transfer, −1 on response transfer.
  - Both in the same cycle → unchanged.
  - A response while outstanding==0 and busy counts as an error; the counter does not underflow.
- Response checking (responses are in order):
  - WAIT_WR / WRITE phase: opcode must be 0x04.
  - Read phase: opcode must be 0x02, and data must equal the pattern for read index j. A checker index j advances on every read response.
  - Each violation increments err_count, saturating at 2^CNTW−1.
  - first_err_addr = base_addr + j*(DW/8) is captured only on the first data mismatch.
  - resp srcaddr/dstaddr are not checked.
- Reset mid-run: returns to IDLE on the next edge; no further requests; busy=0, done=0.

Test Plan:
- count=4, base=0x100, seed=0x11223344, DW=64, ideal memory, ready=1:
  - Exactly 4 writes at 0x100/0x108/0x110/0x118 back-to-back, then 4 reads.
  - Write 0 data = 0x11223345_11223344.
  - Cmd = 0x00C00063 (write) / 0x00C00061 (read).
  - Ends with done=1, pass=1, err_count=0.
- Memory that corrupts bit 0 of the read at 0x110 → done=1, pass=0, err_count=1, first_err_addr=0x110.
- MAXOUT=2, responder delays responses 10 cycles:
  - At most 2 requests are ever unacknowledged.
  - req_valid stays low while 2 are outstanding.
  - Run still passes.
- Random req_ready toggling: payload stable while valid && !ready (assertion); each address issued exactly once per phase.
- count=0 → done and pass=1 one cycle after start, no req_valid. start pulse while busy → ignored.
- reset asserted during READ with 3 outstanding:
  - Next cycle busy=0, req_valid=0.
  - Late responses are absorbed with err_count=0.
  - A new start completes with pass=1.

Source files
------------

// File: rtl/umi_mem_tester.sv
// umi_mem_tester
// ----------------------------------------------------------------------------
// UMI host-side initiator that tests a UMI memory responder. A start pulse
// begins a run with two phases. The write phase writes `count` DW-bit words of
// a seeded pattern to consecutive addresses. The read phase reads the same
// words back and checks each one against the regenerated pattern. The block
// reports busy/done/pass, a saturating error count and the address of the
// first read whose data did not match.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle pulse; begins a run from IDLE or DONE
//   count/base_addr/src_addr/seed  run setup, latched on an accepted start
//   busy/done/pass      run status (pass is meaningful while done=1)
//   err_count           bad responses + data mismatches, saturating
//   first_err_addr      address of the first mismatching read
//   uhost_req_*         UMI request channel (valid/ready)
//   uhost_resp_*        UMI response channel (ready tied high)
//   dbg_state           current FSM state, for checkers and debug
//
// Handshake: a transfer happens on a rising edge where valid && ready. Once
// valid is raised it stays high, and cmd/dstaddr/srcaddr/data stay stable,
// until that transfer. Requests can go out back to back, one per cycle.
// ----------------------------------------------------------------------------
module umi_mem_tester #(
    parameter int DW     = 64,
    parameter int AW     = 64,
    parameter int CW     = 32,
    parameter int CNTW   = 16,
    parameter int MAXOUT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [CNTW-1:0] count,
    input  logic [AW-1:0]   base_addr,
    input  logic [AW-1:0]   src_addr,
    input  logic [31:0]     seed,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [CNTW-1:0] err_count,
    output logic [AW-1:0]   first_err_addr,
    output logic            uhost_req_valid,
    input  logic            uhost_req_ready,
    output logic [CW-1:0]   uhost_req_cmd,
    output logic [AW-1:0]   uhost_req_dstaddr,
    output logic [AW-1:0]   uhost_req_srcaddr,
    output logic [DW-1:0]   uhost_req_data,
    input  logic            uhost_resp_valid,
    output logic            uhost_resp_ready,
    input  logic [CW-1:0]   uhost_resp_cmd,
    input  logic [AW-1:0]   uhost_resp_dstaddr,
    input  logic [AW-1:0]   uhost_resp_srcaddr,
    input  logic [DW-1:0]   uhost_resp_data,
    output logic [2:0]      dbg_state
);

    localparam int LANES = DW / 32;
    localparam int SIZE  = $clog2(DW / 8);
    localparam int OW    = 4;

    // {reserved, eof, eom, reserved, len, size, opcode}
    localparam logic [CW-1:0] CMD_WR =
        CW'({8'h00, 1'b1, 1'b1, 6'd0, 8'h00, 3'(SIZE), 5'h03});
    localparam logic [CW-1:0] CMD_RD =
        CW'({8'h00, 1'b1, 1'b1, 6'd0, 8'h00, 3'(SIZE), 5'h01});

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_WAIT_WR = 3'd2,
        S_READ    = 3'd3,
        S_WAIT_RD = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t          state, state_next;
    logic [CNTW-1:0] cnt_q;
    logic [AW-1:0]   base_q;
    logic [AW-1:0]   src_q;
    logic [31:0]     seed_q;
    logic [CNTW-1:0] req_idx;
    logic [CNTW-1:0] chk_idx;
    logic [OW-1:0]   outstanding;
    logic            first_err_seen;

    // Word idx of the pattern: 32-bit lane k = seed + idx*16 + k (mod 2^32).
    function automatic logic [DW-1:0] pattern(input logic [31:0] s,
                                              input logic [CNTW-1:0] idx);
        logic [DW-1:0] d;
        logic [31:0]   b;
        d = '0;
        b = s + (32'(idx) << 4);
        for (int k = 0; k < LANES; k++) begin
            d[32*k +: 32] = b + 32'(k);
        end
        return d;
    endfunction

    function automatic logic [AW-1:0] addr_of(input logic [AW-1:0] base,
                                              input logic [CNTW-1:0] idx);
        return base + (AW'(idx) << SIZE);
    endfunction

    logic active, issuing, wr_phase, rd_phase;
    logic req_fire, last_req;
    logic resp_counted, resp_unexp, data_mis, resp_bad, err_inc;
    logic accept_start;

    always_comb begin
        active       = (state == S_WRITE) || (state == S_WAIT_WR) ||
                       (state == S_READ)  || (state == S_WAIT_RD);
        issuing      = (state == S_WRITE) || (state == S_READ);
        wr_phase     = (state == S_WRITE) || (state == S_WAIT_WR);
        rd_phase     = (state == S_READ)  || (state == S_WAIT_RD);
        accept_start = start && ((state == S_IDLE) || (state == S_DONE));

        // Outstanding only falls on responses, so once valid is high it
        // cannot drop before the transfer.
        uhost_req_valid   = issuing && (outstanding < OW'(MAXOUT));
        uhost_req_cmd     = (state == S_WRITE) ? CMD_WR : CMD_RD;
        uhost_req_dstaddr = addr_of(base_q, req_idx);
        uhost_req_srcaddr = src_q;
        uhost_req_data    = (state == S_WRITE) ? pattern(seed_q, req_idx) : '0;
        uhost_resp_ready  = 1'b1;

        req_fire = uhost_req_valid && uhost_req_ready;
        last_req = (req_idx == cnt_q - CNTW'(1));

        // Responses outside an active run are dropped without any effect.
        resp_counted = uhost_resp_valid && active && (outstanding != '0);
        resp_unexp   = uhost_resp_valid && active && (outstanding == '0);
        data_mis     = rd_phase && (uhost_resp_data != pattern(seed_q, chk_idx));
        resp_bad     = wr_phase ? (uhost_resp_cmd[4:0] != 5'h04)
                                : ((uhost_resp_cmd[4:0] != 5'h02) || data_mis);
        err_inc      = resp_unexp || (resp_counted && resp_bad);

        busy      = active;
        done      = (state == S_DONE);
        pass      = done && (err_count == '0);
        dbg_state = state;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_next = (count == '0) ? S_DONE : S_WRITE;
            end
            S_WRITE:   if (req_fire && last_req) state_next = S_WAIT_WR;
            S_WAIT_WR: if (outstanding == '0)    state_next = S_READ;
            S_READ:    if (req_fire && last_req) state_next = S_WAIT_RD;
            S_WAIT_RD: if (outstanding == '0)    state_next = S_DONE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt_q          <= '0;
            base_q         <= '0;
            src_q          <= '0;
            seed_q         <= '0;
            req_idx        <= '0;
            chk_idx        <= '0;
            outstanding    <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_seen <= 1'b0;
        end else begin
            state <= state_next;
            if (accept_start) begin
                cnt_q          <= count;
                base_q         <= base_addr;
                src_q          <= src_addr;
                seed_q         <= seed;
                req_idx        <= '0;
                chk_idx        <= '0;
                err_count      <= '0;
                first_err_addr <= '0;
                first_err_seen <= 1'b0;
            end else begin
                if (req_fire) begin
                    req_idx <= last_req ? '0 : req_idx + CNTW'(1);
                end
                if (req_fire && !resp_counted) begin
                    outstanding <= outstanding + OW'(1);
                end else if (!req_fire && resp_counted) begin
                    outstanding <= outstanding - OW'(1);
                end
                if (resp_counted && rd_phase) begin
                    chk_idx <= chk_idx + CNTW'(1);
                end
                if (err_inc && (err_count != '1)) begin
                    err_count <= err_count + CNTW'(1);
                end
                if (resp_counted && data_mis && !first_err_seen) begin
                    first_err_addr <= addr_of(base_q, chk_idx);
                    first_err_seen <= 1'b1;
                end
            end
        end
    end

    // Response addresses and non-opcode command bits are not checked.
    logic unused_resp;
    assign unused_resp = ^{uhost_resp_dstaddr, uhost_resp_srcaddr,
                           uhost_resp_cmd[CW-1:5]};

endmodule

// File: tb/tb_umi_mem_tester.sv
// Self-checking bench for umi_mem_tester with a behavioural memory responder.
module tb_umi_mem_tester;

    localparam int DW     = 64;
    localparam int AW     = 64;
    localparam int CW     = 32;
    localparam int CNTW   = 16;
    localparam int MAXOUT = 3;
    localparam int REQW   = CW + AW + AW + DW;
    localparam logic [AW-1:0] SRC = 64'hABCD_0000_0000_1234;

    logic            clk;
    logic            reset;
    logic            start;
    logic [CNTW-1:0] count;
    logic [AW-1:0]   base_addr;
    logic [AW-1:0]   src_addr;
    logic [31:0]     seed;
    logic            busy, done, pass;
    logic [CNTW-1:0] err_count;
    logic [AW-1:0]   first_err_addr;
    logic            uhost_req_valid, uhost_req_ready;
    logic [CW-1:0]   uhost_req_cmd;
    logic [AW-1:0]   uhost_req_dstaddr, uhost_req_srcaddr;
    logic [DW-1:0]   uhost_req_data;
    logic            uhost_resp_valid, uhost_resp_ready;
    logic [CW-1:0]   uhost_resp_cmd;
    logic [AW-1:0]   uhost_resp_dstaddr, uhost_resp_srcaddr;
    logic [DW-1:0]   uhost_resp_data;
    logic [2:0]      dbg_state;

    umi_mem_tester #(.DW(DW), .AW(AW), .CW(CW), .CNTW(CNTW), .MAXOUT(MAXOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .count(count),
        .base_addr(base_addr), .src_addr(src_addr), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr),
        .uhost_req_valid(uhost_req_valid), .uhost_req_ready(uhost_req_ready),
        .uhost_req_cmd(uhost_req_cmd), .uhost_req_dstaddr(uhost_req_dstaddr),
        .uhost_req_srcaddr(uhost_req_srcaddr), .uhost_req_data(uhost_req_data),
        .uhost_resp_valid(uhost_resp_valid), .uhost_resp_ready(uhost_resp_ready),
        .uhost_resp_cmd(uhost_resp_cmd), .uhost_resp_dstaddr(uhost_resp_dstaddr),
        .uhost_resp_srcaddr(uhost_resp_srcaddr), .uhost_resp_data(uhost_resp_data),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;

    logic [REQW-1:0] exp_q[$];
    logic [63:0]     mem[logic [63:0]];
    logic [CW-1:0]   pend_cmd[$];
    logic [DW-1:0]   pend_data[$];
    int              pend_due[$];
    logic [CW-1:0]   log_cmd[$];
    logic [AW-1:0]   log_dst[$];
    logic [DW-1:0]   log_data[$];
    int              log_cyc[$];

    logic [AW-1:0] corrupt_addr;
    int            resp_delay;
    bit            rand_ready;
    int            tb_out = 0;
    int            tb_max = 0;
    int            cyc = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [31:0] s, input int i);
        logic [DW-1:0] d;
        d[31:0]  = s + 32'(i * 16);
        d[63:32] = s + 32'(i * 16) + 32'd1;
        return d;
    endfunction

    // Expected request stream of a full run: writes then reads, in order.
    task automatic push_run(input int n, input logic [AW-1:0] b, input logic [31:0] s);
        for (int i = 0; i < n; i++)
            exp_q.push_back({32'h00C0_0063, b + 64'(i) * 64'd8, SRC, exp_data(s, i)});
        for (int i = 0; i < n; i++)
            exp_q.push_back({32'h00C0_0061, b + 64'(i) * 64'd8, SRC, 64'h0});
    endtask

    // ---------------- responder / request monitor ----------------
    initial begin
        bit              prev_hold;
        logic [REQW-1:0] prev_payload;
        logic [REQW-1:0] act;
        logic [CW-1:0]   rc;
        logic [DW-1:0]   rd;
        prev_hold          = 1'b0;
        prev_payload       = '0;
        uhost_req_ready    = 1'b1;
        uhost_resp_valid   = 1'b0;
        uhost_resp_cmd     = '0;
        uhost_resp_data    = '0;
        uhost_resp_dstaddr = '0;
        uhost_resp_srcaddr = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (tb_out > tb_max) tb_max = tb_out;
            act = {uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr, uhost_req_data};
            if (tb_out == MAXOUT) check("valid_low_at_cap", uhost_req_valid, 1'b0);
            if (prev_hold && !reset) begin
                check("hold_valid", uhost_req_valid, 1'b1);
                check("hold_payload", act, prev_payload);
            end
            uhost_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            prev_hold    = !reset && uhost_req_valid && !uhost_req_ready;
            prev_payload = act;
            if (uhost_req_valid && uhost_req_ready) begin
                log_cmd.push_back(uhost_req_cmd);
                log_dst.push_back(uhost_req_dstaddr);
                log_data.push_back(uhost_req_data);
                log_cyc.push_back(cyc);
                check("req_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("req_payload", act, exp_q.pop_front());
                tb_out++;
                if (uhost_req_cmd[4:0] == 5'h03) begin
                    mem[uhost_req_dstaddr] = uhost_req_data;
                    rc = 32'h00C0_0064;
                    rd = '0;
                end else begin
                    rd = mem.exists(uhost_req_dstaddr) ? mem[uhost_req_dstaddr] : 64'h0;
                    if (uhost_req_dstaddr == corrupt_addr) rd[0] = ~rd[0];
                    rc = 32'h00C0_0062;
                end
                pend_cmd.push_back(rc);
                pend_data.push_back(rd);
                pend_due.push_back(cyc + 1 + resp_delay);
            end
            if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
                uhost_resp_valid = 1'b1;
                uhost_resp_cmd   = pend_cmd.pop_front();
                uhost_resp_data  = pend_data.pop_front();
                void'(pend_due.pop_front());
                tb_out--;
            end else begin
                uhost_resp_valid = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic [AW-1:0] b, input logic [31:0] s);
        count     = CNTW'(n);
        base_addr = b;
        src_addr  = SRC;
        seed      = s;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && !done; i++) step();
        check({tag, "_done"}, done, 1'b1);
    endtask

    task automatic clear_log();
        log_cmd.delete();
        log_dst.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        count        = '0;
        base_addr    = '0;
        src_addr     = '0;
        seed         = '0;
        rand_ready   = 1'b0;
        resp_delay   = 0;
        corrupt_addr = 64'h1;
        repeat (3) step();

        // Reset state (checked while reset is held)
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_err", err_count, 16'h0);
        check("rst_first", first_err_addr, 64'h0);
        check("rst_req_valid", uhost_req_valid, 1'b0);
        check("rst_resp_ready", uhost_resp_ready, 1'b1);
        check("rst_state", dbg_state, 3'd0);
        reset = 1'b0;
        step();

        // A: ideal memory, 4 words
        clear_log();
        push_run(4, 64'h100, 32'h1122_3344);
        run(4, 64'h100, 32'h1122_3344);
        check("a_busy", busy, 1'b1);
        check("a_done_low", done, 1'b0);
        wait_done(300, "a");
        check("a_pass", pass, 1'b1);
        check("a_err", err_count, 16'h0);
        check("a_nreq", log_cmd.size(), 8);
        check("a_wcmd", log_cmd[0], 32'h00C0_0063);
        check("a_rcmd", log_cmd[4], 32'h00C0_0061);
        check("a_wdata0", log_data[0], 64'h1122_3345_1122_3344);
        check("a_addr3", log_dst[3], 64'h118);
        check("a_b2b", log_cyc[3] - log_cyc[0], 3);
        check("a_q_empty", exp_q.size(), 0);

        // B: read of 0x110 comes back with bit 0 flipped
        corrupt_addr = 64'h110;
        push_run(4, 64'h100, 32'h1122_3344);
        run(4, 64'h100, 32'h1122_3344);
        wait_done(300, "b");
        check("b_pass", pass, 1'b0);
        check("b_err", err_count, 16'd1);
        check("b_first", first_err_addr, 64'h110);
        check("b_q_empty", exp_q.size(), 0);
        corrupt_addr = 64'h1;

        // C: slow responder, outstanding cap
        resp_delay = 10;
        tb_max     = 0;
        push_run(8, 64'h400, 32'hDEAD_BEEF);
        run(8, 64'h400, 32'hDEAD_BEEF);
        wait_done(1000, "c");
        check("c_pass", pass, 1'b1);
        check("c_max_out", tb_max, MAXOUT);
        check("c_q_empty", exp_q.size(), 0);
        resp_delay = 0;

        // D: random req_ready, address and pattern wrap-around
        rand_ready = 1'b1;
        clear_log();
        push_run(10, 64'hFFFF_FFFF_FFFF_FFF0, 32'hFFFF_FFF0);
        run(10, 64'hFFFF_FFFF_FFFF_FFF0, 32'hFFFF_FFF0);
        wait_done(2000, "d");
        check("d_pass", pass, 1'b1);
        check("d_err", err_count, 16'h0);
        check("d_wrap_addr", log_dst[2], 64'h0);
        check("d_q_empty", exp_q.size(), 0);
        rand_ready = 1'b0;

        // E: count=0, then start while busy
        clear_log();
        run(0, 64'h300, 32'h0);
        check("e_zero_done", done, 1'b1);
        check("e_zero_pass", pass, 1'b1);
        check("e_zero_busy", busy, 1'b0);
        repeat (3) step();
        check("e_zero_noreq", log_cmd.size(), 0);
        push_run(6, 64'h200, 32'h5);
        run(6, 64'h200, 32'h5);
        step();
        run(2, 64'h900, 32'h9);
        wait_done(500, "e");
        check("e_pass", pass, 1'b1);
        check("e_nreq", log_cmd.size(), 12);
        check("e_q_empty", exp_q.size(), 0);

        // F: reset during READ with MAXOUT requests outstanding
        resp_delay = 10;
        push_run(8, 64'h600, 32'h1234);
        run(8, 64'h600, 32'h1234);
        for (int i = 0; i < 400 && !(dbg_state == 3'd3 && tb_out == MAXOUT); i++) step();
        check("f_reach", {dbg_state == 3'd3, tb_out == MAXOUT}, 2'b11);
        reset = 1'b1;
        step();
        check("f_busy", busy, 1'b0);
        check("f_req_valid", uhost_req_valid, 1'b0);
        check("f_done", done, 1'b0);
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 100 && pend_due.size() != 0; i++) step();
        repeat (2) step();
        check("f_drained", pend_due.size(), 0);
        check("f_err", err_count, 16'h0);
        check("f_idle", dbg_state, 3'd0);
        resp_delay = 0;
        push_run(4, 64'h700, 32'h77);
        run(4, 64'h700, 32'h77);
        wait_done(300, "f2");
        check("f2_pass", pass, 1'b1);
        check("f2_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
